// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 prefix decoder feeding a first-word
// fall-through event FIFO with overflow reporting.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done_tick,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow_tick
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t state_q, state_d;

    logic          is_e0, is_f0, is_ctrl;
    logic          emit, emit_ext, emit_brk;
    logic          full, push, pop;

    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        is_e0   = (rx_data == 8'hE0);
        is_f0   = (rx_data == 8'hF0);
        is_ctrl = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default:             is_ctrl = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A prefix byte adds its flag; any other byte returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (rx_done_tick) begin
            if (is_ctrl) begin
                state_d = IDLE;
            end else if (is_e0) begin
                case (state_q)
                    IDLE, GOT_E0: state_d = GOT_E0;
                    default:      state_d = GOT_E0F0;
                endcase
            end else if (is_f0) begin
                case (state_q)
                    IDLE, GOT_F0: state_d = GOT_F0;
                    default:      state_d = GOT_E0F0;
                endcase
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        emit     = rx_done_tick && !is_ctrl && !is_e0 && !is_f0;
        emit_ext = (state_q == GOT_E0) || (state_q == GOT_E0F0);
        emit_brk = (state_q == GOT_F0) || (state_q == GOT_E0F0);
    end

    always_comb begin
        ev_valid = (count_q != '0);
        full     = (count_q == (AW + 1)'(FIFO_DEPTH));
        pop      = ev_valid && ev_ready;
        // A full FIFO still accepts when the head leaves this cycle.
        push          = emit && (!full || pop);
        overflow_tick = emit && full && !pop;
        {ev_ext, ev_break, ev_code} = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {emit_ext, emit_brk, rx_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign ev_count = count_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a queue-based model
// checked every cycle, plus literal checks of the key scenarios.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_count;
    logic       overflow_tick;

    int n_cmp = 0;
    int n_bad = 0;
    logic last_ovf;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_break     (ev_break),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_count     (ev_count),
        .overflow_tick(overflow_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: pending prefix flags and a queue of decoded events.
    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
    } ev_t;

    ev_t mq[$];
    bit  m_e0, m_f0;

    function automatic bit is_ctrl(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                         8'hFC, 8'hFE, 8'hFF};
    endfunction

    function automatic bit emits(input logic [7:0] b);
        return !is_ctrl(b) && b != 8'hE0 && b != 8'hF0;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit do_pop;
        bit was_full;
        ev_t e;
        if (reset) begin
            mq.delete();
            m_e0 = 0;
            m_f0 = 0;
        end else begin
            do_pop   = (mq.size() > 0) && ev_ready;
            was_full = (mq.size() == DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (rx_done_tick) begin
                if (is_ctrl(rx_data)) begin
                    m_e0 = 0;
                    m_f0 = 0;
                end else if (rx_data == 8'hE0) begin
                    m_e0 = 1;
                end else if (rx_data == 8'hF0) begin
                    m_f0 = 1;
                end else begin
                    e.code = rx_data;
                    e.ext  = m_e0;
                    e.brk  = m_f0;
                    if (!was_full || do_pop) mq.push_back(e);
                    m_e0 = 0;
                    m_f0 = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_ovf;
        if (!reset) begin
            exp_ovf = rx_done_tick && emits(rx_data)
                      && mq.size() == DEPTH && !ev_ready;
            chk("m_valid", int'(ev_valid), int'(mq.size() > 0));
            chk("m_count", int'(ev_count), mq.size());
            chk("m_ovf", int'(overflow_tick), int'(exp_ovf));
            if (mq.size() > 0) begin
                chk("m_code", int'(ev_code), int'(mq[0].code));
                chk("m_ext", int'(ev_ext), int'(mq[0].ext));
                chk("m_brk", int'(ev_break), int'(mq[0].brk));
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic rdy);
        rx_data      = b;
        rx_done_tick = 1'b1;
        ev_ready     = rdy;
        #2 last_ovf  = overflow_tick;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        ev_ready     = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        ev_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
        ev_ready = 1'b0;
    endtask

    task automatic head(input string nm, input logic [7:0] c,
                        input logic x, input logic k);
        chk({nm, "_valid"}, int'(ev_valid), 1);
        chk({nm, "_code"}, int'(ev_code), int'(c));
        chk({nm, "_ext"}, int'(ev_ext), int'(x));
        chk({nm, "_brk"}, int'(ev_break), int'(k));
    endtask

    task automatic drain(input string nm, input logic [7:0] c0,
                         input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3);
        logic [7:0] exp_c [4];
        exp_c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            head(nm, exp_c[i], 1'b0, 1'b0);
            idle(1, 1'b1);
        end
        chk({nm, "_empty"}, int'(ev_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        rx_data      = 8'h00;
        rx_done_tick = 1'b0;
        ev_ready     = 1'b0;
        last_ovf     = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(ev_count), 0);
        chk("rst_code", int'(ev_code), 0);
        chk("rst_ext", int'(ev_ext), 0);
        chk("rst_brk", int'(ev_break), 0);
        chk("rst_ovf", int'(overflow_tick), 0);
        reset = 1'b0;

        // Make then break of 1C with ev_ready held high.
        send(8'h1C, 1'b1);
        head("mk1c", 8'h1C, 1'b0, 1'b0);
        send(8'hF0, 1'b1);
        chk("mk1c_popped", int'(ev_valid), 0);
        send(8'h1C, 1'b1);
        head("br1c", 8'h1C, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Extended make and break.
        send(8'hE0, 1'b0);
        send(8'h75, 1'b0);
        head("ext_mk", 8'h75, 1'b1, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        chk("ext_cnt", int'(ev_count), 2);
        idle(1, 1'b1);
        head("ext_br", 8'h75, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Repeated and swapped prefixes.
        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h6B, 1'b0);
        head("f0e0", 8'h6B, 1'b1, 1'b1);
        idle(1, 1'b1);
        send(8'hE0, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h14, 1'b0);
        head("e0e0", 8'h14, 1'b1, 1'b0);
        idle(1, 1'b1);
        send(8'hF0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h12, 1'b0);
        head("f0f0", 8'h12, 1'b0, 1'b1);
        idle(1, 1'b1);

        // Overflow with no consumer.
        send(8'h15, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        chk("full_cnt", int'(ev_count), 4);
        send(8'h2C, 1'b0);
        chk("ovf_pulse", int'(last_ovf), 1);
        chk("ovf_cnt", int'(ev_count), 4);
        drain("ovf", 8'h15, 8'h1D, 8'h24, 8'h2D);

        // Full with simultaneous push and pop.
        send(8'h15, 1'b0);
        send(8'h1D, 1'b0);
        send(8'h24, 1'b0);
        send(8'h2D, 1'b0);
        send(8'h2C, 1'b1);
        chk("pp_ovf", int'(last_ovf), 0);
        chk("pp_cnt", int'(ev_count), 4);
        drain("pp", 8'h1D, 8'h24, 8'h2D, 8'h2C);
        idle(2, 1'b1);

        // Control byte discards a prefix.
        send(8'hE0, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h1C, 1'b0);
        chk("ctl_cnt", int'(ev_count), 1);
        head("ctl", 8'h1C, 1'b0, 1'b0);
        idle(1, 1'b1);

        // Reset in the middle of a prefix.
        send(8'hF0, 1'b0);
        reset = 1'b1;
        #2 reset = 1'b0;
        send(8'h1C, 1'b0);
        head("rst_pfx", 8'h1C, 1'b0, 1'b0);
        idle(1, 1'b1);

        // Asynchronous reset with events queued.
        send(8'h1C, 1'b0);
        send(8'h32, 1'b0);
        send(8'h21, 1'b0);
        chk("q3_cnt", int'(ev_count), 3);
        reset = 1'b1;
        #1;
        chk("arst_valid", int'(ev_valid), 0);
        chk("arst_count", int'(ev_count), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(3, 1'b0);
        chk("post_rst_valid", int'(ev_valid), 0);
        chk("post_rst_code", int'(ev_code), 0);
        send(8'h4B, 1'b0);
        head("post_rst", 8'h4B, 1'b0, 1'b0);
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx_data  input  8  byte from the upstream PS/2 receiver, valid when rx_done_tick=1.
REQ-005 SHALL have port rx_done_tick  input  1  one-cycle strobe, one received byte.
REQ-006 SHALL have port ev_code  output  8  scan code of the FIFO head event.
REQ-007 SHALL have port ev_ext  output  1  head event was E0-prefixed (extended key).
REQ-008 SHALL have port ev_break  output  1  head event is a release (F0-prefixed).
REQ-009 SHALL have port ev_valid  output  1  FIFO non-empty; head event presented.
REQ-010 SHALL have port ev_ready  input  1  consumer accepts head event when ev_valid=1.
REQ-011 SHALL have port ev_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow_tick  output  1  one-cycle pulse, event dropped because FIFO full.

Function
REQ-013 SHALL decode PS/2 scan-code set 2 with a 4-state prefix FSM: IDLE, GOT_E0, GOT_F0, GOT_E0F0; FSM advances only on cycles with rx_done_tick=1.
REQ-014 SHALL, in IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0; other non-control byte -> emit {code, ext=0, brk=0}, stay IDLE.
REQ-015 SHALL, in GOT_E0: 0xF0 -> GOT_E0F0; 0xE0 -> stay GOT_E0; other non-control byte -> emit {code, ext=1, brk=0}, -> IDLE.
REQ-016 SHALL, in GOT_F0: 0xE0 -> GOT_E0F0; 0xF0 -> stay GOT_F0; other non-control byte -> emit {code, ext=0, brk=1}, -> IDLE.
REQ-017 SHALL, in GOT_E0F0: 0xE0/0xF0 -> stay; other non-control byte -> emit {code, ext=1, brk=1}, -> IDLE.
REQ-018 SHALL treat control bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF as: no event, FSM -> IDLE (prefix discarded), from any state.
REQ-019 SHALL write an emitted event into the FIFO on the rx_done_tick cycle; ev_valid/ev_* reflect it from the next cycle (latency 1 clk when FIFO was empty).
REQ-020 SHALL present the FIFO head combinationally from registered storage (first-word fall-through); ev_* hold stable while ev_valid=1 and ev_ready=0.
REQ-021 SHALL pop the head on a cycle with ev_valid=1 and ev_ready=1; ev_ready with ev_valid=0 has no effect.
REQ-022 SHALL, when full and an event is emitted without a same-cycle pop, drop the new event, keep FIFO contents, pulse overflow_tick for that cycle; FSM still -> IDLE.
REQ-023 SHALL, when full with same-cycle push and pop, accept both; ev_count unchanged.
REQ-024 SHALL, when empty, ignore pop; push and ev_ready same cycle: event written, not popped that cycle.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; ev_count = writes - reads, range 0..FIFO_DEPTH.

Reset
REQ-026 SHALL on reset: FSM=IDLE, pointers=0, ev_count=0, ev_valid=0, overflow_tick=0, ev_code=0x00, ev_ext=0, ev_break=0, all FIFO entries cleared.
REQ-027 SHALL on reset mid-sequence (e.g. after 0xE0) discard the partial prefix; next byte decoded from IDLE.

Verification
REQ-028 SHALL cover: bytes 0x1C, then 0xF0,0x1C, ev_ready=1 -> events {1C,0,0} then {1C,0,1}, each ev_valid 1 clk after final byte's tick.
REQ-029 SHALL cover: 0xE0,0x75 then 0xE0,0xF0,0x75 -> {75,1,0} then {75,1,1}.
REQ-030 SHALL cover: ev_ready=0, 5 make codes 0x15,0x1D,0x24,0x2D,0x2C with depth 4 -> ev_count=4, overflow_tick on 5th, head 0x15, then draining yields 15,1D,24,2D.
REQ-031 SHALL cover: FIFO full, 5th byte tick coincident with ev_ready=1 -> no overflow_tick, ev_count stays 4, last entry 0x2C.
REQ-032 SHALL cover: 0xE0,0xAA,0x1C -> single event {1C,0,0}; 0xF0 then reset then 0x1C -> {1C,0,0}.
REQ-033 SHALL cover: reset asserted with 3 events queued -> ev_valid=0, ev_count=0 immediately (asynchronously), no event after release until new byte.
